// File: rtl/spike_uart_packetizer_if.sv
// Handshake bundle between the spike packetizer and its environment.
// The master side drives sampling control and channel levels. The slave side drives the UART line and status.
interface spike_uart_packetizer_if #(
  parameter int N_CH = 18
);
  logic            uart_start;
  logic [N_CH-1:0] ch_in;
  logic            uart_txd;
  logic            tx_busy;
  logic            sample_tick;
  logic            frame_done;
  logic            overflow;

  modport master (
    output uart_start, ch_in,
    input  uart_txd, tx_busy, sample_tick, frame_done, overflow
  );
  modport slave (
    input  uart_start, ch_in,
    output uart_txd, tx_busy, sample_tick, frame_done, overflow
  );
endinterface

// File: rtl/spike_uart_packetizer.sv
// Periodic spike-vector sampler feeding a snapshot FIFO and an 8N1 UART framer.
// Packet format: SYNC, data bytes LSB-first, XOR checksum of the data bytes.
module spike_uart_packetizer #(
  parameter int         N_CH        = 18,
  parameter int         CLK_DIV     = 576,
  parameter int         SAMPLE_BITS = 64,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input logic                     sys_clk,
  input logic                     sys_reset,
  spike_uart_packetizer_if.slave  io
);
  localparam int NB = (N_CH + 7) / 8;
  localparam int P  = SAMPLE_BITS * CLK_DIV;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NB + 2);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  // Sampler
  logic [CW-1:0] per_q;
  logic          tick;

  assign tick = io.uart_start && (per_q == CW'(P - 1));

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset)                    per_q <= '0;
    else if (!io.uart_start || tick)  per_q <= '0;
    else                              per_q <= per_q + CW'(1);
  end

  // Snapshot FIFO; pointers carry a wrap bit to tell full from empty
  logic [N_CH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_q, rd_q;
  logic            empty, full, push, pop, ovf_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = tick && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= io.ch_in;
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
      if (tick && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Serialiser
  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [2:0]          bit_q, bit_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NB-1:0][7:0]  data_q, data_d, head;
  logic [7:0]          chk_q, chk_d, head_chk, cur_byte;
  logic                txd_q, txd_d, frame_done;
  logic                div_end, last_byte;

  assign head      = (NB*8)'(mem_q[rd_q[AW-1:0]]);
  assign div_end   = (div_q == DW'(CLK_DIV - 1));
  assign last_byte = (idx_q == IW'(NB + 1));

  always_comb begin
    head_chk = '0;
    for (int i = 0; i < NB; i++) head_chk = head_chk ^ head[i];
  end

  // idx 0 is SYNC, 1..NB are data, NB+1 is the checksum
  always_comb begin
    cur_byte = chk_q;
    if (idx_q == '0) cur_byte = SYNC_BYTE;
    for (int i = 0; i < NB; i++)
      if (idx_q == IW'(i + 1)) cur_byte = data_q[i];
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    data_d     = data_q;
    chk_d      = chk_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        pop     = 1'b1;
        data_d  = head;
        chk_d   = head_chk;
        idx_d   = '0;
        div_d   = '0;
        bit_d   = '0;
        txd_d   = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          txd_d   = cur_byte[0];
          state_d = S_DATA;
        end else div_d = div_q + DW'(1);
      end
      S_DATA: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = cur_byte[bit_q + 3'd1];
          end
        end else div_d = div_q + DW'(1);
      end
      S_STOP: begin
        if (div_end) begin
          div_d = '0;
          if (last_byte) begin
            frame_done = 1'b1;
            txd_d      = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            txd_d   = 1'b0;
            state_d = S_START;
          end
        end else div_d = div_q + DW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      chk_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
      txd_q   <= txd_d;
    end
  end

  assign io.uart_txd    = txd_q;
  assign io.tx_busy     = (state_q != S_IDLE);
  assign io.sample_tick = tick;
  assign io.frame_done  = frame_done;
  assign io.overflow    = ovf_q;
endmodule

// File: tb/tb_spike_uart_packetizer.sv
// Bench: UART line decoder plus a period/snapshot reference model for the packetizer.
module tb_spike_uart_packetizer;
  localparam int N_CH    = 18;
  localparam int CLK_DIV = 4;
  localparam int SB      = 64;
  localparam int SBF     = 20;
  localparam int NB      = (N_CH + 7) / 8;
  localparam int PLEN    = NB + 2;
  localparam int P       = SB * CLK_DIV;
  localparam int BITC    = 10 * CLK_DIV;

  logic sys_clk = 1'b0;
  logic sys_reset;
  always #5 sys_clk = ~sys_clk;

  spike_uart_packetizer_if #(.N_CH(N_CH)) bus ();
  spike_uart_packetizer_if #(.N_CH(N_CH)) bus_f ();

  spike_uart_packetizer #(.N_CH(N_CH), .CLK_DIV(CLK_DIV), .SAMPLE_BITS(SB),
                          .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5))
    dut (.sys_clk(sys_clk), .sys_reset(sys_reset), .io(bus));

  spike_uart_packetizer #(.N_CH(N_CH), .CLK_DIV(CLK_DIV), .SAMPLE_BITS(SBF),
                          .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5))
    dut_f (.sys_clk(sys_clk), .sys_reset(sys_reset), .io(bus_f));

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int t_start = 0;
  int first_tick = -1;
  int last_fd = 0, prev_fd = 0;

  logic [7:0] exp_q[$];
  logic [7:0] dec_log[$];

  logic [1:0] txd_w, busy_w, fd_w;
  assign txd_w  = {bus_f.uart_txd, bus.uart_txd};
  assign busy_w = {bus_f.tx_busy, bus.tx_busy};
  assign fd_w   = {bus_f.frame_done, bus.frame_done};

  bit         act[2];
  int         ph[2], bidx[2], pkt_start[2], n_frames[2];
  logic [7:0] sh[2];
  logic [7:0] fpkt[PLEN];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic byte_done(input int i, input bit last);
    logic [8*NB-1:0] fv;
    logic [7:0]      x;
    if (i == 0) begin
      dec_log.push_back(sh[0]);
      if (exp_q.size() == 0) chk("unexpected_byte", {56'd0, sh[0]}, 64'hX);
      else chk("byte", sh[0], exp_q.pop_front());
    end else begin
      fpkt[bidx[1]] = sh[1];
      if (last) begin
        fv = (8*NB)'(bus_f.ch_in);
        x  = 8'h00;
        chk("fast_sync", fpkt[0], 8'hA5);
        for (int k = 0; k < NB; k++) begin
          chk("fast_data", fpkt[k+1], fv[k*8 +: 8]);
          x = x ^ fpkt[k+1];
        end
        chk("fast_chk", fpkt[PLEN-1], x);
      end
    end
    if (last) begin
      chk("frame_len", cyc - pkt_start[i], PLEN * BITC - 1);
      n_frames[i]++;
      if (i == 0) begin prev_fd = last_fd; last_fd = cyc; end
    end
  endtask

  // Line decoder for both instances plus the main instance's sampling model
  always @(negedge sys_clk) begin
    logic            fd_exp, exp_tick;
    logic [8*NB-1:0] v;
    logic [7:0]      x;
    int              j;
    if (sys_reset) begin
      for (int i = 0; i < 2; i++) begin act[i] = 0; ph[i] = 0; bidx[i] = 0; end
      exp_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        fd_exp = 1'b0;
        if (!act[i]) begin
          if (i == 0 && exp_q.size() == 0) chk("idle_busy", busy_w[0], 1'b0);
          if (txd_w[i] === 1'b0) begin
            act[i] = 1; ph[i] = 0; sh[i] = 8'h00;
            if (bidx[i] == 0) pkt_start[i] = cyc;
          end
        end
        if (act[i]) begin
          chk("busy", busy_w[i], 1'b1);
          if (ph[i] % CLK_DIV == CLK_DIV / 2) begin
            j = ph[i] / CLK_DIV;
            if (j == 0)      chk("start_bit", txd_w[i], 1'b0);
            else if (j == 9) chk("stop_bit", txd_w[i], 1'b1);
            else             sh[i][j-1] = txd_w[i];
          end
          if (ph[i] == BITC - 1) begin
            fd_exp = (bidx[i] == PLEN - 1);
            byte_done(i, fd_exp);
            act[i]  = 0;
            bidx[i] = fd_exp ? 0 : bidx[i] + 1;
          end else ph[i]++;
        end
        chk("frame_done", fd_w[i], fd_exp);
      end
      exp_tick = bus.uart_start && (((cyc - t_start) % P) == P - 1);
      chk("sample_tick", bus.sample_tick, exp_tick);
      if (bus.sample_tick === 1'b1 && first_tick < 0) first_tick = cyc;
      if (exp_tick) begin
        v = (8*NB)'(bus.ch_in);
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NB; k++) begin
          exp_q.push_back(v[k*8 +: 8]);
          x = x ^ v[k*8 +: 8];
        end
        exp_q.push_back(x);
      end
    end
  end

  initial begin
    logic [7:0] exp2[PLEN];
    int budget, nf;
    exp2 = '{8'hA5, 8'hC3, 8'hA5, 8'h02, 8'h64};
    sys_reset = 1'b1;
    bus.uart_start = 1'b0;   bus.ch_in = '0;
    bus_f.uart_start = 1'b0; bus_f.ch_in = '0;
    step(3);
    chk("rst_txd", bus.uart_txd, 1'b1);
    chk("rst_busy", bus.tx_busy, 1'b0);
    chk("rst_tick", bus.sample_tick, 1'b0);
    chk("rst_fd", bus.frame_done, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_txd_f", bus_f.uart_txd, 1'b1);
    sys_reset = 1'b0;

    // Sampling disabled: line stays idle
    step(2000);
    chk("idle_frames", n_frames[0], 0);
    chk("idle_bytes", dec_log.size(), 0);
    chk("idle_txd", bus.uart_txd, 1'b1);

    // First packet from a fixed pattern
    bus.ch_in = 18'h2A5C3;
    bus.uart_start = 1'b1;
    t_start = cyc;
    first_tick = -1;
    budget = 3 * P;
    while (n_frames[0] < 1 && budget > 0) begin step(1); budget--; end
    chk("wait_first_frame", budget > 0, 1'b1);
    chk("first_tick_cycle", first_tick - t_start, P - 1);
    chk("first_pkt_len", dec_log.size(), PLEN);
    for (int k = 0; k < PLEN; k++) chk("first_pkt_byte", dec_log[k], exp2[k]);
    chk("ovf_after_first", bus.overflow, 1'b0);

    // All-zero channels, periodic packets
    bus.ch_in = '0;
    budget = 4 * P;
    while (n_frames[0] < 3 && budget > 0) begin step(1); budget--; end
    chk("wait_zero_frames", budget > 0, 1'b1);
    chk("pkt_period", last_fd - prev_fd, P);

    // Randomised channel activity
    for (int r = 0; r < 3 * P; r++) begin
      bus.ch_in = N_CH'($urandom);
      step(1);
    end
    chk("ovf_random", bus.overflow, 1'b0);

    // Drop uart_start mid-packet: the in-flight packet still completes
    budget = 2 * P;
    while (!(act[0] && bidx[0] == 2) && budget > 0) begin step(1); budget--; end
    chk("wait_midpkt", budget > 0, 1'b1);
    nf = n_frames[0];
    bus.uart_start = 1'b0;
    budget = 2 * P;
    while ((bus.tx_busy !== 1'b0 || exp_q.size() != 0) && budget > 0) begin step(1); budget--; end
    chk("wait_drain", budget > 0, 1'b1);
    chk("drain_frames", n_frames[0], nf + 1);
    step(3 * P);
    chk("no_new_frames", n_frames[0], nf + 1);

    // Sampling faster than packets drain -> overflow on the fast instance
    bus_f.ch_in = N_CH'($urandom);
    bus_f.uart_start = 1'b1;
    step(5000);
    bus_f.uart_start = 1'b0;
    budget = 4 * PLEN * BITC;
    while (bus_f.tx_busy !== 1'b0 && budget > 0) begin step(1); budget--; end
    chk("wait_fast_drain", budget > 0, 1'b1);
    chk("fast_overflow", bus_f.overflow, 1'b1);
    chk("fast_frames", n_frames[1] >= 20, 1'b1);
    chk("main_ovf_clear", bus.overflow, 1'b0);

    // Reset in the middle of a data bit
    bus.ch_in = N_CH'($urandom);
    bus.uart_start = 1'b1;
    t_start = cyc;
    budget = 2 * P;
    while (!(act[0] && bidx[0] == 1 && ph[0] >= 8) && budget > 0) begin step(1); budget--; end
    chk("wait_mid_data", budget > 0, 1'b1);
    bus.uart_start = 1'b0;
    sys_reset = 1'b1;
    #1;
    chk("abort_txd", bus.uart_txd, 1'b1);
    chk("abort_busy", bus.tx_busy, 1'b0);
    chk("abort_ovf_f", bus_f.overflow, 1'b0);
    step(2);
    sys_reset = 1'b0;
    nf = n_frames[0];
    bus.ch_in = N_CH'($urandom);
    bus.uart_start = 1'b1;
    t_start = cyc;
    budget = 3 * P;
    while (n_frames[0] < nf + 1 && budget > 0) begin step(1); budget--; end
    chk("wait_post_reset", budget > 0, 1'b1);
    bus.uart_start = 1'b0;
    step(10);
    chk("post_reset_queue", exp_q.size(), 0);
    chk("post_reset_ovf", bus.overflow, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
